rule_scheduler: RTL

- Rule-firing scheduler that sits directly upstream of the generated `system` model.
- Produces the one-hot rule-enable vector `io_en_a` the model consumes, from per-rule guard flags the model exports.
- Fires at most one enabled rule per step, using round-robin fairness, so bounded traces exercise every rule.
- Flags a deadlock when step requests repeatedly find no guard true.

---
 rtl/rule_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rule_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rule_scheduler
// Description : Round-robin rule-firing scheduler that feeds the one-hot
//               rule-enable vector of the generated `system` model. It fires
//               at most one guarded rule per step request and flags a
//               deadlock after DEADLOCK_LIMIT consecutive empty requests.
//               Optional build macro RULE_SCHED_LFSR_EN selects the search
//               start index from a 16-bit Galois LFSR instead of the
//               round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rule_scheduler #(
  parameter int NUM_RULES      = 4,
  parameter int COUNT_W        = 16,
  parameter int DEADLOCK_LIMIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_step,
  input  logic [NUM_RULES-1:0] io_guard,
  output logic [NUM_RULES-1:0] io_en_a,
  output logic                 io_busy,
  output logic                 io_deadlock,
  output logic [COUNT_W-1:0]   io_fire_count
);

  localparam int PTR_W   = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam int STALL_W = $clog2(DEADLOCK_LIMIT + 1);

  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(DEADLOCK_LIMIT);
  localparam logic [PTR_W-1:0]   LAST_RULE   = PTR_W'(NUM_RULES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_RULES-1:0] en_q, en_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [PTR_W-1:0]     start_idx;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_RULES-1:0] grant_oh;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [STALL_W-1:0]   stall_inc;

`ifdef RULE_SCHED_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR step: shift right, fold taps in when the bit shifted out is 1
  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  end

  // LFSR free-runs every cycle outside reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Randomised search start: low LFSR byte folded into the rule range
  always_comb begin
    start_idx = PTR_W'(int'({24'd0, lfsr_q[7:0]}) % NUM_RULES);
  end
`else
  // Round-robin search start: the rule after the last one granted
  always_comb begin
    start_idx = ptr_q;
  end
`endif

  // Circular priority search: first true guard at or above start_idx, wrapping
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_RULES; k++) begin
      idx = PTR_W'((int'({{(32-PTR_W){1'b0}}, start_idx}) + k) % NUM_RULES);
      if (!grant_vld && io_guard[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Pointer successor and stall increment used by the state machine
  always_comb begin
    ptr_nxt   = (grant_idx == LAST_RULE) ? '0 : grant_idx + PTR_W'(1);
    stall_inc = stall_q + STALL_W'(1);
  end

  // Next-state logic: IDLE evaluates requests, FIRE lasts one cycle, DEAD is terminal
  always_comb begin
    state_d = state_q;
    en_d    = '0;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (io_step) begin
          if (grant_vld) begin
            en_d    = grant_oh;
            ptr_d   = ptr_nxt;
            stall_d = '0;
            state_d = ST_FIRE;
          end else begin
            stall_d = stall_inc;
            if (stall_inc == STALL_LIMIT) begin
              state_d = ST_DEAD;
            end
          end
        end
      end
      ST_FIRE: begin
        state_d = ST_IDLE;
        if (count_q != '1) begin
          count_d = count_q + COUNT_W'(1);
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything immediately, even mid-FIRE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      ptr_q   <= '0;
      stall_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      count_q <= count_d;
    end
  end

  // Outputs decode directly from registered state
  always_comb begin
    io_en_a       = en_q;
    io_busy       = (state_q == ST_FIRE);
    io_deadlock   = (state_q == ST_DEAD);
    io_fire_count = count_q;
  end

endmodule
`default_nettype wire
